// File: rtl/pull_data_if.sv
// pull_data_if: byte-in / speed-word-out link between a byte source and the
// pull_data reassembler.
// Ports: master (byte source, drives write/data, observes results),
//        slave  (reassembler, consumes bytes, drives speed/valid/error/busy).
interface pull_data_if #(
   parameter int DATA_SIZE   = 8,
   parameter int WIDTH_SPEED = 14
);

   // Byte channel: one byte per cycle while write is high, never stalled.
   logic                   write;
   logic [DATA_SIZE-1:0]   data;

   // Reassembled word and status, all registered in the reassembler.
   logic [WIDTH_SPEED-1:0] speed;
   logic                   valid;
   logic                   frame_err;
   logic                   timeout_err;
   logic                   busy;

   modport master (
      output write,
      output data,
      input  speed,
      input  valid,
      input  frame_err,
      input  timeout_err,
      input  busy
   );

   modport slave (
      input  write,
      input  data,
      output speed,
      output valid,
      output frame_err,
      output timeout_err,
      output busy
   );

endinterface

// File: rtl/pull_data.sv
// pull_data: rebuilds a WIDTH_SPEED-bit speed word from two DATA_SIZE-bit
// bytes (low byte first, then high byte) and flags stalled or corrupted frames.
// Latency: valid/speed one cycle after the high-byte strobe; never back-pressures.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   bus.write    byte strobe, one byte per high cycle
//   bus.data     byte value, sampled only with write
//   bus.speed    last good reassembled word, held between frames
//   bus.valid    one-cycle pulse, speed updated in the same cycle
//   bus.frame_err    one-cycle pulse, high byte carried nonzero pad bits
//   bus.timeout_err  one-cycle pulse, high byte missed its TIMEOUT window
//   bus.busy     high while a low byte is held
// Parameters must satisfy DATA_SIZE < WIDTH_SPEED <= 2*DATA_SIZE, TIMEOUT >= 2.
module pull_data #(
   parameter int WIDTH_SPEED = 14,
   parameter int DATA_SIZE   = 8,
   parameter int TIMEOUT     = 1000
) (
   input  logic          clk,
   input  logic          reset,
   pull_data_if.slave    bus
);

   // Number of meaningful bits carried by the high byte.
   localparam int HI_W  = WIDTH_SPEED - DATA_SIZE;
   // Bits of the high byte above HI_W that must be zero.
   localparam int PAD_W = 2 * DATA_SIZE - WIDTH_SPEED;
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_HI = 1'b1
   } state_t;

   state_t                 state_q,       state_d;
   logic [CNT_W-1:0]       cnt_q,         cnt_d;
   logic [DATA_SIZE-1:0]   low_q,         low_d;
   logic [WIDTH_SPEED-1:0] speed_q,       speed_d;
   logic                   valid_q,       valid_d;
   logic                   frame_err_q,   frame_err_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   pad_nz;

   // With a full 2*DATA_SIZE word there is nothing to pad, so a frame error
   // is impossible by construction.
   generate
      if (PAD_W > 0) begin : g_pad
         assign pad_nz = |bus.data[DATA_SIZE-1:HI_W];
      end else begin : g_nopad
         assign pad_nz = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      low_d         = low_q;
      speed_d       = speed_q;
      valid_d       = 1'b0;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.write) begin
               low_d   = bus.data;
               cnt_d   = '0;
               state_d = WAIT_HI;
            end
         end

         WAIT_HI: begin
            // A write always beats an expiring counter in the same cycle,
            // so the last cycle of the window still accepts the high byte.
            if (bus.write) begin
               state_d = IDLE;
               if (pad_nz) begin
                  frame_err_d = 1'b1;
               end else begin
                  speed_d = {bus.data[HI_W-1:0], low_q};
                  valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = IDLE;
               timeout_err_d = 1'b1;
               low_d         = '0;
            end else begin
               // Leaving at CNT_LAST keeps the counter saturated below wrap.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         low_q         <= '0;
         speed_q       <= '0;
         valid_q       <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         low_q         <= low_d;
         speed_q       <= speed_d;
         valid_q       <= valid_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.speed       = speed_q;
   assign bus.valid       = valid_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.busy        = (state_q == WAIT_HI);

endmodule

// File: tb/tb_pull_data.sv
// tb_pull_data: directed checks of pull_data; dut_a uses the default TIMEOUT,
// dut_b uses TIMEOUT=4 for window-edge and random frame tests.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_pull_data;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   int vcnt_b    = 0;
   int ecnt_b    = 0;
   int excl_viol = 0;

   pull_data_if #(.DATA_SIZE(8), .WIDTH_SPEED(14)) bus_a ();
   pull_data_if #(.DATA_SIZE(8), .WIDTH_SPEED(14)) bus_b ();

   pull_data #(.WIDTH_SPEED(14), .DATA_SIZE(8), .TIMEOUT(1000)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   pull_data #(.WIDTH_SPEED(14), .DATA_SIZE(8), .TIMEOUT(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse bookkeeping on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus_b.valid) vcnt_b++;
         if (bus_b.frame_err || bus_b.timeout_err) ecnt_b++;
         if (int'(bus_a.valid) + int'(bus_a.frame_err) + int'(bus_a.timeout_err) > 1)
            excl_viol++;
         if (int'(bus_b.valid) + int'(bus_b.frame_err) + int'(bus_b.timeout_err) > 1)
            excl_viol++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_a.write = 1'b0; bus_a.data = 8'h00;
      bus_b.write = 1'b0; bus_b.data = 8'h00;
      tick();
      tick();
      n_checks++;
      if (bus_a.speed !== 14'h0 || bus_a.valid !== 1'b0 || bus_a.frame_err !== 1'b0 ||
          bus_a.timeout_err !== 1'b0 || bus_a.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: speed=%h v=%b fe=%b te=%b busy=%b, want all zero",
                  bus_a.speed, bus_a.valid, bus_a.frame_err, bus_a.timeout_err, bus_a.busy);
      end
      n_checks++;
      if (bus_b.speed !== 14'h0 || bus_b.valid !== 1'b0 || bus_b.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b: speed=%h v=%b busy=%b, want all zero",
                  bus_b.speed, bus_b.valid, bus_b.busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus_a.write = 1'b1; bus_a.data = 8'h34;
      tick();
      n_checks++;
      if (bus_a.busy !== 1'b1 || bus_a.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_low: busy=%b valid=%b, want busy=1 valid=0", bus_a.busy, bus_a.valid);
      end
      bus_a.data = 8'h12;
      tick();
      bus_a.write = 1'b0;
      n_checks++;
      if (bus_a.valid !== 1'b1 || bus_a.speed !== 14'h1234 || bus_a.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_word: valid=%b speed=%h busy=%b, want 1 1234 0",
                  bus_a.valid, bus_a.speed, bus_a.busy);
      end
      tick();
      n_checks++;
      if (bus_a.valid !== 1'b0 || bus_a.speed !== 14'h1234) begin
         n_fail++;
         $display("FAIL b2b_hold: valid=%b speed=%h, want 0 1234", bus_a.valid, bus_a.speed);
      end
   endtask

   task automatic test_gap();
      bus_a.write = 1'b1; bus_a.data = 8'hFF;
      tick();
      bus_a.write = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (bus_a.busy !== 1'b1 || bus_a.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_wait: busy=%b te=%b, want 1 0", bus_a.busy, bus_a.timeout_err);
      end
      bus_a.write = 1'b1; bus_a.data = 8'h3F;
      tick();
      bus_a.write = 1'b0;
      n_checks++;
      if (bus_a.valid !== 1'b1 || bus_a.speed !== 14'h3FFF ||
          bus_a.frame_err !== 1'b0 || bus_a.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_word: valid=%b speed=%h fe=%b te=%b, want 1 3fff 0 0",
                  bus_a.valid, bus_a.speed, bus_a.frame_err, bus_a.timeout_err);
      end
      tick();
   endtask

   task automatic test_frame_err();
      bus_a.write = 1'b1; bus_a.data = 8'h01;
      tick();
      bus_a.data = 8'h40;
      tick();
      bus_a.write = 1'b0;
      n_checks++;
      if (bus_a.frame_err !== 1'b1 || bus_a.valid !== 1'b0 ||
          bus_a.speed !== 14'h3FFF || bus_a.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err: fe=%b valid=%b speed=%h busy=%b, want 1 0 3fff 0",
                  bus_a.frame_err, bus_a.valid, bus_a.speed, bus_a.busy);
      end
      // New low byte immediately in the cycle after the error pulse.
      bus_a.write = 1'b1; bus_a.data = 8'h02;
      tick();
      n_checks++;
      if (bus_a.frame_err !== 1'b0 || bus_a.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_err_clear: fe=%b busy=%b, want 0 1", bus_a.frame_err, bus_a.busy);
      end
      bus_a.data = 8'h00;
      tick();
      bus_a.write = 1'b0;
      n_checks++;
      if (bus_a.valid !== 1'b1 || bus_a.speed !== 14'h0002) begin
         n_fail++;
         $display("FAIL frame_recover: valid=%b speed=%h, want 1 0002", bus_a.valid, bus_a.speed);
      end
      tick();
   endtask

   task automatic test_timeout();
      bus_b.write = 1'b1; bus_b.data = 8'hAA;
      tick();
      bus_b.write = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if (bus_b.busy !== 1'b1 || bus_b.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre%0d: busy=%b te=%b, want 1 0", i, bus_b.busy, bus_b.timeout_err);
         end
      end
      tick();
      n_checks++;
      if (bus_b.timeout_err !== 1'b1 || bus_b.busy !== 1'b0 || bus_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_fire: te=%b busy=%b valid=%b, want 1 0 0",
                  bus_b.timeout_err, bus_b.busy, bus_b.valid);
      end
      tick();
      n_checks++;
      if (bus_b.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_pulse: te=%b, want 0", bus_b.timeout_err);
      end
   endtask

   task automatic test_timeout_edge();
      bus_b.write = 1'b1; bus_b.data = 8'hAA;
      tick();
      bus_b.write = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      // High byte in the last cycle of the window: write beats expiry.
      bus_b.write = 1'b1; bus_b.data = 8'h05;
      tick();
      bus_b.write = 1'b0;
      n_checks++;
      if (bus_b.valid !== 1'b1 || bus_b.timeout_err !== 1'b0 || bus_b.speed !== 14'h05AA) begin
         n_fail++;
         $display("FAIL timeout_edge: valid=%b te=%b speed=%h, want 1 0 05aa",
                  bus_b.valid, bus_b.timeout_err, bus_b.speed);
      end
      tick();
      n_checks++;
      if (bus_b.timeout_err !== 1'b0 || bus_b.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_edge_after: te=%b busy=%b, want 0 0", bus_b.timeout_err, bus_b.busy);
      end
   endtask

   task automatic test_reset_midframe();
      int e0;
      e0 = ecnt_b;
      bus_a.write = 1'b1; bus_a.data = 8'h55;
      tick();
      bus_a.write = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (bus_a.busy !== 1'b0 || bus_a.speed !== 14'h0 || bus_a.frame_err !== 1'b0 ||
          bus_a.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b speed=%h fe=%b te=%b, want 0 0 0 0",
                  bus_a.busy, bus_a.speed, bus_a.frame_err, bus_a.timeout_err);
      end
      bus_a.write = 1'b1; bus_a.data = 8'h10;
      tick();
      bus_a.data = 8'h00;
      tick();
      bus_a.write = 1'b0;
      n_checks++;
      if (bus_a.valid !== 1'b1 || bus_a.speed !== 14'h0010 ||
          bus_a.frame_err !== 1'b0 || bus_a.timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_word: valid=%b speed=%h fe=%b te=%b, want 1 0010 0 0",
                  bus_a.valid, bus_a.speed, bus_a.frame_err, bus_a.timeout_err);
      end
      tick();
      n_checks++;
      if (ecnt_b !== e0) begin
         n_fail++;
         $display("FAIL mid_reset_b_err: errors=%0d, want %0d", ecnt_b, e0);
      end
   endtask

   task automatic test_random_frames();
      int v0, e0;
      logic [7:0]  lo, hi;
      logic [13:0] exp_w;
      int gap;
      v0 = vcnt_b;
      e0 = ecnt_b;
      for (int f = 0; f < 100; f++) begin
         lo = 8'($urandom_range(0, 255));
         hi = 8'($urandom_range(0, 63));
         exp_w = {hi[5:0], lo};
         bus_b.write = 1'b1; bus_b.data = lo;
         tick();
         bus_b.write = 1'b0;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         bus_b.write = 1'b1; bus_b.data = hi;
         tick();
         bus_b.write = 1'b0;
         n_checks++;
         if (bus_b.valid !== 1'b1 || bus_b.speed !== exp_w) begin
            n_fail++;
            $display("FAIL rand_frame%0d: valid=%b speed=%h, want 1 %h", f, bus_b.valid, bus_b.speed, exp_w);
         end
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
      end
      tick();
      n_checks++;
      if (vcnt_b - v0 !== 100) begin
         n_fail++;
         $display("FAIL rand_valid_count: got %0d, want 100", vcnt_b - v0);
      end
      n_checks++;
      if (ecnt_b - e0 !== 0) begin
         n_fail++;
         $display("FAIL rand_err_count: got %0d, want 0", ecnt_b - e0);
      end
   endtask

   task automatic test_exclusive();
      n_checks++;
      if (excl_viol !== 0) begin
         n_fail++;
         $display("FAIL pulse_exclusive: %0d overlapping cycles, want 0", excl_viol);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gap();
      test_frame_err();
      test_timeout();
      test_timeout_edge();
      test_reset_midframe();
      test_random_frames();
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pull_data.md
# pull_data

Receive-side byte reassembler for the speed link. Accepts a stream of `DATA_SIZE`-bit bytes qualified by single-cycle `write` strobes, low byte first, then high byte. Rebuilds the `WIDTH_SPEED`-bit speed word and presents it with a one-cycle `valid` pulse. Sits at the far end of the byte channel, between the byte source (FIFO/UART RX) and the speed consumer; it also detects stalled or corrupted frames.

## Interface
- `WIDTH_SPEED`, 14: reassembled word width; must satisfy `DATA_SIZE < WIDTH_SPEED <= 2*DATA_SIZE`.
- `DATA_SIZE`, 8: byte width.
- `TIMEOUT`, 1000: maximum number of clock cycles allowed between the low byte and the high byte; must be at least 2.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `write`  in  1  byte strobe; each cycle it is high delivers exactly one byte.
- `data`  in  `DATA_SIZE`  byte value; sampled only when `write`=1.
- `speed`  out  `WIDTH_SPEED`  last good reassembled word; holds its value between frames.
- `valid`  out  1  one-cycle pulse; `speed` is updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse; the high byte had nonzero pad bits.
- `timeout_err`  out  1  one-cycle pulse; the high byte did not arrive within `TIMEOUT` cycles.
- `busy`  out  1  high while a low byte is held and the block waits for the high byte.

## Operation
- Two-state FSM with the following states and transitions:
  - IDLE: on `write`, store `data` into the low register, clear the timeout counter, and go to WAIT_HI.
  - WAIT_HI, on `write` with pad bits zero: go to IDLE. Next cycle, `speed` = {`data`[`WIDTH_SPEED-DATA_SIZE-1`:0], low} and `valid`=1.
  - WAIT_HI, on `write` with pad bits nonzero: go to IDLE. Next cycle, `frame_err`=1; `speed` is unchanged.
  - WAIT_HI, no `write`: increment the counter. When the counter reaches `TIMEOUT-1`, go to IDLE. Next cycle, `timeout_err`=1 and the low byte is discarded.
- Pad bits are `data`[`DATA_SIZE-1`:`WIDTH_SPEED-DATA_SIZE`]. When `WIDTH_SPEED` = 2*`DATA_SIZE`, there are no pad bits and `frame_err` never fires.
- `busy` = 1 exactly when the state is WAIT_HI.
- Timeout counter: width is `$clog2(TIMEOUT)`. It saturates and never wraps.
- Priority rules:
  - If `write` arrives in the same cycle the counter reaches `TIMEOUT-1`, the write wins: the byte is taken as the high byte and no timeout is raised.
  - A `write` in the cycle that follows an error or a `valid` is handled from IDLE, so it is a new low byte. No gap cycle is required between frames.
- Reset forces, on the next edge, and overrides any other event in the same cycle:
  - state IDLE, counter 0, low register 0;
  - `speed`=0, `valid`=0, `frame_err`=0, `timeout_err`=0, `busy`=0.
- Reset mid-frame (in WAIT_HI) drops the held low byte with no error pulse.
- `valid`, `frame_err` and `timeout_err` are mutually exclusive in every cycle.

## Timing
- All outputs are registered.
- Latency from the high-byte `write` edge to `valid`=1 is 1 cycle; `speed` changes in that same cycle.
- Back-to-back strobes, low then high in consecutive cycles, are supported. Minimum frame period is 2 cycles; sustained throughput is one word per 2 cycles.
- Let T0 be the cycle in which the low byte is taken:
  - a high byte at T0+k with k ≤ `TIMEOUT` is accepted;
  - with no write, `timeout_err` pulses at T0+`TIMEOUT`+1.
- `write` is never back-pressured; the block accepts a byte in every cycle.

## Test plan
- Reset, then bytes 0x34 and 0x12 on consecutive cycles → one cycle after the second strobe: `valid`=1, `speed`=14'h1234, `busy` 1 for one cycle only.
- Low byte 0xFF, 5 idle cycles, high byte 0x3F → `speed`=14'h3FFF, `valid` pulse; `frame_err` and `timeout_err` stay 0.
- Low byte 0x01, high byte 0x40 (pad bit set) → `frame_err` pulse, `valid`=0, `speed` keeps the previous value 14'h3FFF. Next pair 0x02/0x00 → `speed`=14'h0002.
- `TIMEOUT`=4: low byte 0xAA then no write → `timeout_err` at T0+5, `busy` falls at the same edge. Repeat with the high byte at exactly T0+4 → `valid` with no timeout (simultaneous-event priority).
- Low byte 0x55, then `reset` asserted for one cycle, then bytes 0x10/0x00 → no error pulse; `valid` with `speed`=14'h0010, proving the stale low byte was dropped.
- 100 random frames of back-to-back pairs, with random idle gaps from 0 to `TIMEOUT`-1 → exactly 100 `valid` pulses, each `speed` matching the reference word, and no error pulses.
